xillybus_wrapper_udiv_seq: RTL and testbench

//  Sequential radix-2 restoring unsigned divider; the inverse of the 15x15->30 unsigned

---
 rtl/xillybus_wrapper_udiv_seq_pkg.sv | 19 +
 rtl/xillybus_wrapper_udiv_step.sv | 30 +++
 rtl/xillybus_wrapper_udiv_seq.sv | 132 +++++++++++++
 tb/tb_xillybus_wrapper_udiv_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/xillybus_wrapper_udiv_seq_pkg.sv
// Shared definitions for the sequential unsigned divider.
// Contents: FSM state encoding and a constant clog2 used to size the iteration counter.
package xillybus_wrapper_udiv_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time width computation.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(v)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/xillybus_wrapper_udiv_step.sv
// One radix-2 restoring division step (purely combinational).
// Ports:
//   r_i       partial remainder from the previous step (always < divisor)
//   divisor_i divisor
//   bit_i     next dividend bit, MSB first
//   r_o       partial remainder after this step
//   qbit_o    quotient bit produced by this step
// The partial remainder is carried as M bits: after every step it is below the
// divisor, so only the shifted value {r, bit} needs the extra top bit, and that
// bit only matters for the compare.
module xillybus_wrapper_udiv_step #(
  parameter int unsigned M = 15
) (
  input  logic [M-1:0] r_i,
  input  logic [M-1:0] divisor_i,
  input  logic         bit_i,
  output logic [M-1:0] r_o,
  output logic         qbit_o
);

  logic [M:0]   shifted_c;
  logic [M-1:0] diff_c;

  assign shifted_c = {r_i, bit_i};
  assign qbit_o    = (shifted_c >= {1'b0, divisor_i});
  // True difference is below the divisor whenever it is taken, so M bits suffice.
  assign diff_c    = shifted_c[M-1:0] - divisor_i;
  assign r_o       = qbit_o ? diff_c : shifted_c[M-1:0];

endmodule

// File: rtl/xillybus_wrapper_udiv_seq.sv
// Sequential radix-2 restoring unsigned divider, N-bit dividend by M-bit divisor,
// controlled over an ap_ctrl_hs style handshake.
// Ports:
//   ap_clk, ap_rst          clock, synchronous active-high reset
//   ap_start / ap_ready     request / operands accepted this cycle (combinational)
//   ap_idle / ap_done       idle indicator / one-cycle result-valid pulse
//   din0, din1              dividend, divisor (captured when ap_ready=1)
//   dout_quot, dout_rem     quotient, remainder (held until the next completion)
//   div_zero                last division had a zero divisor
module xillybus_wrapper_udiv_seq
  import xillybus_wrapper_udiv_seq_pkg::*;
#(
  parameter logic [31:0] ID             = 32'd1,
  parameter int unsigned DIVIDEND_WIDTH = 30,
  parameter int unsigned DIVISOR_WIDTH  = 15
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      ap_start,
  output logic                      ap_ready,
  output logic                      ap_idle,
  output logic                      ap_done,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic [DIVIDEND_WIDTH-1:0] dout_quot,
  output logic [DIVISOR_WIDTH-1:0]  dout_rem,
  output logic                      div_zero
);

  localparam int unsigned N     = DIVIDEND_WIDTH;
  localparam int unsigned M     = DIVISOR_WIDTH;
  localparam int unsigned CNT_W = clog2(N + 1);

  if (N < M) begin : g_width_check
    $error("xillybus_wrapper_udiv_seq %0d: DIVIDEND_WIDTH must be >= DIVISOR_WIDTH", ID);
  end

  state_e           state_q, state_d;
  logic [N-1:0]     sh_q, sh_d;      // dividend in, quotient out, shifted MSB first
  logic [M-1:0]     r_q, r_d;
  logic [M-1:0]     dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     quot_q, quot_d;
  logic [M-1:0]     rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [M-1:0]     step_r;
  logic             step_qbit;

  xillybus_wrapper_udiv_step #(.M(M)) u_step (
    .r_i       (r_q),
    .divisor_i (dvs_q),
    .bit_i     (sh_q[N-1]),
    .r_o       (step_r),
    .qbit_o    (step_qbit)
  );

  assign ap_idle   = (state_q == ST_IDLE);
  assign ap_done   = (state_q == ST_DONE);
  assign ap_ready  = ap_start & ap_idle;
  assign dout_quot = quot_q;
  assign dout_rem  = rem_q;
  assign div_zero  = dz_q;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          state_d = ST_RUN;
          sh_d    = din0;
          dvs_d   = din1;
          r_d     = '0;
          cnt_d   = CNT_W'(N - 1);
        end
      end
      ST_RUN: begin
        sh_d = {sh_q[N-2:0], step_qbit};
        r_d  = step_r;
        if (cnt_q == '0) begin
          // Results are taken straight from the final step so they land with DONE.
          state_d = ST_DONE;
          if (dvs_q == '0) begin
            quot_d = '1;
            rem_d  = '0;
            dz_d   = 1'b1;
          end else begin
            quot_d = {sh_q[N-2:0], step_qbit};
            rem_d  = step_r;
            dz_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_xillybus_wrapper_udiv_seq.sv
// Directed testbench for xillybus_wrapper_udiv_seq (default 30/15 configuration).
module tb_xillybus_wrapper_udiv_seq;

  logic        ap_clk;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_idle;
  logic        ap_done;
  logic [29:0] din0;
  logic [14:0] din1;
  logic [29:0] dout_quot;
  logic [14:0] dout_rem;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  xillybus_wrapper_udiv_seq #(
    .ID(32'd1), .DIVIDEND_WIDTH(30), .DIVISOR_WIDTH(15)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ap_start  (ap_start),
    .ap_ready  (ap_ready),
    .ap_idle   (ap_idle),
    .ap_done   (ap_done),
    .din0      (din0),
    .din1      (din1),
    .dout_quot (dout_quot),
    .dout_rem  (dout_rem),
    .div_zero  (div_zero)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Issue one division from an IDLE cycle; return at the cycle ap_done is seen.
  // lat = cycles from the capture cycle (cycle 0) to ap_done; 100 means timeout.
  task automatic do_op(input logic [29:0] a, input logic [14:0] b,
                       output int lat, output logic rdy0);
    int c;
    din0 = a;
    din1 = b;
    ap_start = 1'b1;
    #1;
    rdy0 = ap_ready;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    din0 = 30'h2AAA_AAAA;
    din1 = 15'h5555;
    c = 1;
    while (!ap_done && c < 100) begin
      @(posedge ap_clk); #1;
      c++;
    end
    lat = c;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; ap_start = 1'b0; din0 = '0; din1 = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: idle=%b done=%b ready=%b, required 1 0 0", ap_idle, ap_done, ap_ready);
    end
    checks++;
    if (dout_quot !== 30'd0 || dout_rem !== 15'd0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: quot=%0d rem=%0d dz=%b, required 0 0 0", dout_quot, dout_rem, div_zero);
    end
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
  endtask

  task automatic test_basic(input string name, input logic [29:0] a, input logic [14:0] b,
                            input logic [29:0] eq, input logic [14:0] er, input logic edz);
    int lat;
    logic rdy0;
    do_op(a, b, lat, rdy0);
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: ap_ready=%b in capture cycle, required 1", name, rdy0);
    end
    checks++;
    if (lat !== 31) begin
      errors++;
      $display("FAIL %s_latency: ap_done at cycle %0d, required 31", name, lat);
    end
    checks++;
    if (dout_quot !== eq || dout_rem !== er || div_zero !== edz) begin
      errors++;
      $display("FAIL %s_result: quot=%0d rem=%0d dz=%b, required quot=%0d rem=%0d dz=%b",
               name, dout_quot, dout_rem, div_zero, eq, er, edz);
    end
    @(posedge ap_clk); #1;
    checks++;
    if (ap_done !== 1'b0 || ap_idle !== 1'b1 || dout_quot !== eq || dout_rem !== er) begin
      errors++;
      $display("FAIL %s_hold: done=%b idle=%b quot=%0d rem=%0d, required 0 1 %0d %0d",
               name, ap_done, ap_idle, dout_quot, dout_rem, eq, er);
    end
  endtask

  // ap_start held high for four operations: ready only at cycles 0,32,64,96.
  task automatic test_back_to_back();
    logic [29:0] a [4];
    logic [14:0] b [4];
    logic [29:0] eq;
    logic [14:0] er;
    int op;
    for (int i = 0; i < 4; i++) begin
      a[i] = 30'($urandom);
      b[i] = 15'($urandom_range(1, 32767));
    end
    for (int k = 0; k < 128; k++) begin
      op = k / 32;
      ap_start = 1'b1;
      if (k % 32 == 0) begin
        din0 = a[op];
        din1 = b[op];
      end else begin
        din0 = 30'($urandom);
        din1 = 15'($urandom);
      end
      #1;
      checks++;
      if (ap_ready !== (k % 32 == 0)) begin
        errors++;
        $display("FAIL b2b_ready: cycle %0d ap_ready=%b, required %b", k, ap_ready, (k % 32 == 0));
      end
      if (k % 32 == 31) begin
        eq = a[op] / 30'(b[op]);
        er = 15'(a[op] % 30'(b[op]));
        checks++;
        if (ap_done !== 1'b1 || dout_quot !== eq || dout_rem !== er || div_zero !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result%0d: done=%b quot=%0d rem=%0d dz=%b, required 1 %0d %0d 0",
                   op, ap_done, dout_quot, dout_rem, div_zero, eq, er);
        end
      end
      @(posedge ap_clk); #1;
    end
    ap_start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic rdy0;
    logic seen_done;
    din0 = 30'd1000000; din1 = 15'd3; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    repeat (9) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || dout_quot !== 30'd0 ||
        dout_rem !== 15'd0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: idle=%b done=%b quot=%0d rem=%0d dz=%b, required 1 0 0 0 0",
               ap_idle, ap_done, dout_quot, dout_rem, div_zero);
    end
    ap_rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge ap_clk); #1;
      if (ap_done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_nodone: ap_done seen=%b after abort, required 0", seen_done);
    end
    do_op(30'd1000, 15'd3, lat, rdy0);
    checks++;
    if (lat !== 31 || dout_quot !== 30'd333 || dout_rem !== 15'd1 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: lat=%0d quot=%0d rem=%0d dz=%b, required 31 333 1 0",
               lat, dout_quot, dout_rem, div_zero);
    end
    @(posedge ap_clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic("d1000000_7",  30'd1000000,     15'd7,      30'd142857,      15'd1, 1'b0);
    test_basic("max_exact",   30'h3FFF_FFFF,   15'h7FFF,   30'd32769,       15'd0, 1'b0);
    test_basic("small_5_9",   30'd5,           15'd9,      30'd0,           15'd5, 1'b0);
    test_basic("div_by_1",    30'd12345678,    15'd1,      30'd12345678,    15'd0, 1'b0);
    test_basic("div_by_0",    30'd1234,        15'd0,      30'h3FFF_FFFF,   15'd0, 1'b1);
    test_basic("after_zero",  30'd100,         15'd7,      30'd14,          15'd2, 1'b0);
    test_back_to_back();
    @(posedge ap_clk); #1;
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
